zap_wb_ram_slave: RTL and testbench

- Wishbone B3 responder: a single-port 32-bit RAM with byte enables, classic and incrementing-burst cycles, programmable wait states and address-range error reporting.
- Terminates the bus that the cache/TLB master arbiter drives. Used as the on-chip memory model and the boot RAM behind the ZAP instruction and data ports.
- Responses are fully registered: ack, err and data all come from flops.

---
 rtl/zap_wb_ram_slave.sv | 152 +++++++++++++++
 tb/tb_zap_wb_ram_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_ram_slave.sv
// Wishbone B3 single-port RAM responder: byte enables, classic and incrementing bursts,
// programmable wait states and out-of-range error termination. All responses are registered.
module zap_wb_ram_slave #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SINGLE = 2'd2;
  localparam logic [1:0] BURST  = 2'd3;

  localparam logic [2:0] CTI_INCR = 3'b010;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] beat_addr;
  logic        is_burst;

  logic [31:0] next_addr;
  logic [31:0] resp_addr;
  logic [31:0] resp_rdata;
  logic        resp_ok;
  logic        resp_burst;
  logic [1:0]  resp_state;
  logic        do_resp;
  logic        wr_commit;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  assign next_addr = beat_addr + 32'd4;

  // A beat is answered from the live address in IDLE, the next linear address while
  // streaming a burst, and the held beat address otherwise (wait states, pause resume).
  always_comb begin
    resp_addr  = beat_addr;
    resp_burst = 1'b1;
    do_resp    = 1'b0;
    case (state)
      IDLE: begin
        resp_addr  = i_wb_adr;
        resp_burst = (i_wb_cti == CTI_INCR);
        do_resp    = i_wb_stb && (WAIT_STATES == 0);
      end
      WAIT: begin
        resp_burst = is_burst;
        do_resp    = (cnt == 4'd1);
      end
      BURST: begin
        if (o_wb_ack) resp_addr = next_addr;
        do_resp = i_wb_stb && !(o_wb_ack && i_wb_cti != CTI_INCR);
      end
      default: ;
    endcase
    do_resp    = do_resp && i_wb_cyc;
    resp_ok    = addr_ok(resp_addr);
    resp_rdata = mem[word_idx(resp_addr)];
    resp_state = (resp_ok && resp_burst) ? BURST : SINGLE;
  end

  // The acked beat's data is taken in its ack cycle; abort and reset both suppress it.
  assign wr_commit = o_wb_ack && i_wb_cyc && i_wb_stb && i_wb_wen && !i_reset;

  always_ff @(posedge i_clk) begin
    if (wr_commit) begin
      for (int n = 0; n < 4; n++)
        if (i_wb_sel[n]) mem[word_idx(beat_addr)][8*n +: 8] <= i_wb_dat[8*n +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      beat_addr <= 32'd0;
      is_burst  <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_dat  <= 32'd0;
    end else if (!i_wb_cyc) begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      state    <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_wb_stb) begin
            beat_addr <= i_wb_adr;
            is_burst  <= (i_wb_cti == CTI_INCR);
            if (WAIT_STATES != 0) begin
              cnt   <= 4'(WAIT_STATES);
              state <= WAIT;
            end
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        SINGLE: begin
          o_wb_ack <= 1'b0;
          o_wb_err <= 1'b0;
          state    <= IDLE;
        end
        BURST: begin
          if (o_wb_ack && i_wb_cti != CTI_INCR) begin
            o_wb_ack <= 1'b0;
            state    <= IDLE;
          end else if (i_wb_stb) begin
            if (o_wb_ack) beat_addr <= next_addr;
          end else begin
            o_wb_ack <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_resp) begin
        o_wb_ack <= resp_ok;
        o_wb_err <= !resp_ok;
        o_wb_dat <= (resp_ok && !i_wb_wen) ? resp_rdata : 32'd0;
        state    <= resp_state;
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_ram_slave.sv
// Directed bench for zap_wb_ram_slave: one instance with no wait states, one with three,
// each selected by its own cyc line over a shared request bus.
module tb_zap_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc0 = 1'b0, cyc1 = 1'b0, stb = 1'b0, wen = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic [2:0]  cti = 3'b000;
  logic [31:0] dat0, dat1;
  logic        ack0, err0, ack1, err1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  zap_wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc0), .i_wb_stb(stb), .i_wb_wen(wen),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0));

  zap_wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc1), .i_wb_stb(stb), .i_wb_wen(wen),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat1), .o_wb_ack(ack1), .o_wb_err(err1));

  typedef struct {
    int          d;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] v;
    logic        ea;
    logic        ee;
    logic [31:0] eq;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input int d, input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] v,
                              input logic ea, input logic ee, input logic [31:0] eq);
    vec_t r;
    r.d = d; r.w = w; r.s = s; r.a = a; r.v = v; r.ea = ea; r.ee = ee; r.eq = eq;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic get(input int d, output logic a, output logic e, output logic [31:0] q);
    if (d != 0) begin a = ack1; e = err1; q = dat1; end
    else begin a = ack0; e = err0; q = dat0; end
  endtask

  // Classic cycle: hold the request until ack/err, keep it through the ack cycle, then drop.
  task automatic run_vec(input vec_t v, input string nm);
    logic        ra, re;
    logic [31:0] rq;
    int          lat;
    wen = v.w; sel = v.s; adr = v.a; wdat = v.v; cti = 3'b000; stb = 1'b1;
    if (v.d != 0) cyc1 = 1'b1; else cyc0 = 1'b1;
    lat = 0; ra = 1'b0; re = 1'b0; rq = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      tick;
      get(v.d, ra, re, rq);
      if (ra || re) begin lat = n; break; end
    end
    chk({nm, " resp"}, {ra, re, rq}, {v.ea, v.ee, v.eq});
    chk({nm, " latency"}, lat, (v.d != 0) ? 4 : 1);
    tick;
    stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0;
    get(v.d, ra, re, rq);
    chk({nm, " drop"}, {ra, re}, 2'b00);
    tick;
  endtask

  initial begin
    logic        ra, re;
    logic [31:0] rq;
    int          lat;

    vecs[0]  = mk(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0);
    vecs[1]  = mk(0, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 4'hF, 32'h20,   32'hFFFFFFFF, 1, 0, 32'h0);
    vecs[3]  = mk(0, 1, 4'h5, 32'h20,   32'h11223344, 1, 0, 32'h0);
    vecs[4]  = mk(0, 0, 4'hF, 32'h20,   32'h0,        1, 0, 32'hFF22FF44);
    vecs[5]  = mk(0, 1, 4'h0, 32'h10,   32'h0,        1, 0, 32'h0);
    vecs[6]  = mk(0, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF);
    vecs[7]  = mk(0, 0, 4'hF, 32'h1000, 32'h0,        0, 1, 32'h0);
    vecs[8]  = mk(0, 0, 4'hF, 32'h13,   32'h0,        0, 1, 32'h0);
    vecs[9]  = mk(0, 1, 4'hF, 32'h1004, 32'h12345678, 0, 1, 32'h0);
    vecs[10] = mk(0, 1, 4'hF, 32'h40,   32'h1,        1, 0, 32'h0);
    vecs[11] = mk(0, 1, 4'hF, 32'h44,   32'h2,        1, 0, 32'h0);
    vecs[12] = mk(0, 1, 4'hF, 32'h48,   32'h3,        1, 0, 32'h0);
    vecs[13] = mk(0, 1, 4'hF, 32'h4C,   32'h4,        1, 0, 32'h0);
    vecs[14] = mk(0, 1, 4'hF, 32'hFF8,  32'hAAAA0001, 1, 0, 32'h0);
    vecs[15] = mk(0, 1, 4'hF, 32'hFFC,  32'hAAAA0002, 1, 0, 32'h0);
    vecs[16] = mk(0, 0, 4'hF, 32'hFFC,  32'h0,        1, 0, 32'hAAAA0002);
    vecs[17] = mk(0, 1, 4'hF, 32'h0,    32'h0BADF00D, 1, 0, 32'h0);
    vecs[18] = mk(0, 0, 4'hF, 32'h0,    32'h0,        1, 0, 32'h0BADF00D);
    vecs[19] = mk(0, 1, 4'hF, 32'h204,  32'h55555555, 1, 0, 32'h0);
    vecs[20] = mk(0, 1, 4'hF, 32'h300,  32'h77777777, 1, 0, 32'h0);
    vecs[21] = mk(1, 1, 4'hF, 32'h80,   32'h10,       1, 0, 32'h0);
    vecs[22] = mk(1, 1, 4'hF, 32'h84,   32'h20,       1, 0, 32'h0);
    vecs[23] = mk(1, 1, 4'hF, 32'h88,   32'h30,       1, 0, 32'h0);
    vecs[24] = mk(1, 0, 4'hF, 32'h84,   32'h0,        1, 0, 32'h20);
    vecs[25] = mk(1, 0, 4'hF, 32'hFFFFFFFC, 32'h0,    0, 1, 32'h0);
    vecs[26] = mk(1, 0, 4'h3, 32'h80,   32'h0,        1, 0, 32'h10);

    repeat (3) tick;
    rst = 1'b0;
    chk("reset ws0", {ack0, err0, dat0}, 34'h0);
    chk("reset ws3", {ack1, err1, dat1}, 34'h0);
    tick;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // 4-beat incrementing read burst, one beat per cycle.
    sel = 4'hF; wen = 1'b0; adr = 32'h40; cti = 3'b010; stb = 1'b1; cyc0 = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd burst beat%0d", k + 1), {ack0, err0, dat0}, {2'b10, 32'(k + 1)});
      tick;
      if (k < 3) begin adr = 32'h44 + 32'(4 * k); cti = (k == 2) ? 3'b111 : 3'b010; end
    end
    chk("rd burst end", {ack0, err0}, 2'b00);
    cyc0 = 1'b0; stb = 1'b0;
    tick;

    // Wait states plus a two-cycle strobe pause after beat 2.
    wen = 1'b0; adr = 32'h80; cti = 3'b010; stb = 1'b1; cyc1 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (ack1 || err1) begin lat = n; break; end
    end
    chk("ws3 first ack latency", lat, 4);
    chk("ws3 beat1", {ack1, err1, dat1}, {2'b10, 32'h10});
    tick; adr = 32'h84;
    chk("ws3 beat2", {ack1, err1, dat1}, {2'b10, 32'h20});
    tick; stb = 1'b0;
    tick;
    chk("pause cycle a", {ack1, err1}, 2'b00);
    tick;
    chk("pause cycle b", {ack1, err1}, 2'b00);
    stb = 1'b1; adr = 32'h88; cti = 3'b111;
    tick;
    chk("ws3 beat3 after pause", {ack1, err1, dat1}, {2'b10, 32'h30});
    tick;
    chk("ws3 burst end", {ack1, err1}, 2'b00);
    cyc1 = 1'b0; stb = 1'b0;
    tick;

    // Burst running off the top of the RAM.
    wen = 1'b0; adr = 32'hFF8; cti = 3'b010; stb = 1'b1; cyc0 = 1'b1;
    tick;
    chk("top burst beat1", {ack0, err0, dat0}, {2'b10, 32'hAAAA0001});
    tick; adr = 32'hFFC;
    chk("top burst beat2", {ack0, err0, dat0}, {2'b10, 32'hAAAA0002});
    tick; adr = 32'h1000;
    chk("top burst err", {ack0, err0, dat0}, {2'b01, 32'h0});
    tick;
    chk("top burst end", {ack0, err0}, 2'b00);
    cyc0 = 1'b0; stb = 1'b0;
    tick;

    // cyc dropped during the ack cycle of a write: nothing commits.
    wen = 1'b1; sel = 4'hF; adr = 32'h300; wdat = 32'h99999999; cti = 3'b000;
    stb = 1'b1; cyc0 = 1'b1;
    tick;
    chk("abort ack", {ack0, err0}, 2'b10);
    cyc0 = 1'b0;
    tick;
    chk("abort drop", {ack0, err0}, 2'b00);
    stb = 1'b0;
    tick;
    run_vec(mk(0, 0, 4'hF, 32'h300, 32'h0, 1, 0, 32'h77777777), "abort readback");

    // Reset during beat 2 of a write burst.
    wen = 1'b1; sel = 4'hF; adr = 32'h200; wdat = 32'h11111111; cti = 3'b010;
    stb = 1'b1; cyc0 = 1'b1;
    tick;
    chk("wr burst beat1", {ack0, err0}, 2'b10);
    tick; adr = 32'h204; wdat = 32'h22222222;
    chk("wr burst beat2", {ack0, err0}, 2'b10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("reset mid burst", {ack0, err0, dat0}, 34'h0);
    cyc0 = 1'b0; stb = 1'b0;
    tick;
    run_vec(mk(0, 0, 4'hF, 32'h200, 32'h0, 1, 0, 32'h11111111), "beat1 kept");
    run_vec(mk(0, 0, 4'hF, 32'h204, 32'h0, 1, 0, 32'h55555555), "beat2 dropped");

    get(0, ra, re, rq);
    chk("final idle", {ra, re}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
